// File: rtl/bit6_fa_pair.sv
// Registered dual full adder: two independent 3:2 compressors over six 1-bit operands.
// Optional BIT6_POPCOUNT_EN adds a registered 3-bit count of ones across a..f.
module bit6_fa_pair (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  output logic       out_valid,
  output logic       s1,
  output logic       cout1,
  output logic       s2,
  output logic       cout2
`ifdef BIT6_POPCOUNT_EN
  ,
  output logic [2:0] popcount
`endif
);

  localparam int unsigned GrpW = 2;
  localparam int unsigned PcW  = 3;

  // {carry, sum} of three 1-bit operands
  function automatic logic [GrpW-1:0] fa3(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  logic            valid_d, valid_q;
  logic [GrpW-1:0] grp1_d, grp1_q;
  logic [GrpW-1:0] grp2_d, grp2_q;
`ifdef BIT6_POPCOUNT_EN
  logic [PcW-1:0]  pc_d, pc_q;
`endif

  // Results hold their last value when no new operands arrive
  always_comb begin
    valid_d = in_valid;
    grp1_d  = grp1_q;
    grp2_d  = grp2_q;
`ifdef BIT6_POPCOUNT_EN
    pc_d    = pc_q;
`endif
    if (in_valid) begin
      grp1_d = fa3(a, b, c);
      grp2_d = fa3(d, e, f);
`ifdef BIT6_POPCOUNT_EN
      pc_d   = PcW'(grp1_d) + PcW'(grp2_d);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      grp1_q  <= '0;
      grp2_q  <= '0;
`ifdef BIT6_POPCOUNT_EN
      pc_q    <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      grp1_q  <= grp1_d;
      grp2_q  <= grp2_d;
`ifdef BIT6_POPCOUNT_EN
      pc_q    <= pc_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign s1        = grp1_q[0];
  assign cout1     = grp1_q[1];
  assign s2        = grp2_q[0];
  assign cout2     = grp2_q[1];
`ifdef BIT6_POPCOUNT_EN
  assign popcount  = pc_q;
`endif

endmodule

// File: tb/tb_bit6_fa_pair.sv
// Bench for bit6_fa_pair: arithmetic reference model plus directed literal checks.
module tb_bit6_fa_pair;

  logic clk = 1'b0;
  logic rst_n, in_valid, a, b, c, d, e, f;
  logic out_valid, s1, cout1, s2, cout2;
`ifdef BIT6_POPCOUNT_EN
  logic [2:0] popcount;
`endif

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  bit6_fa_pair dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .out_valid(out_valid), .s1(s1), .cout1(cout1), .s2(s2), .cout2(cout2)
`ifdef BIT6_POPCOUNT_EN
    , .popcount(popcount)
`endif
  );

  // Reference: group results are plain integer sums of the operand bits
  logic       m_valid;
  logic [1:0] m_g1, m_g2;
  logic [2:0] m_pc;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_g1    <= 2'd0;
      m_g2    <= 2'd0;
      m_pc    <= 3'd0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        m_g1 <= 2'(a) + 2'(b) + 2'(c);
        m_g2 <= 2'(d) + 2'(e) + 2'(f);
        m_pc <= 3'($countones({a, b, c, d, e, f}));
      end
    end
  end

  task automatic cmp(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_valid", 4'(out_valid), 4'(m_valid));
      cmp("model_grp1", 4'({cout1, s1}), 4'(m_g1));
      cmp("model_grp2", 4'({cout2, s2}), 4'(m_g2));
`ifdef BIT6_POPCOUNT_EN
      cmp("model_popcount", 4'(popcount), 4'(m_pc));
`endif
    end
  end

  // Drive {a,b,c,d,e,f}; returns after the capturing edge, past the following negedge
  task automatic step(input logic [5:0] v, input logic vld);
    {a, b, c, d, e, f} = v;
    in_valid = vld;
    @(negedge clk);
    #1;
  endtask

  // Literal expectation: {valid, s1, c1, s2, c2}
  task automatic lit(input string name, input logic [4:0] exp);
    checks++;
    if ({out_valid, s1, cout1, s2, cout2} !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name,
               {out_valid, s1, cout1, s2, cout2}, exp, $time);
    end
  endtask

`ifdef BIT6_POPCOUNT_EN
  task automatic lit_pc(input string name, input logic [2:0] exp);
    checks++;
    if (popcount !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, popcount, exp);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    step(6'b111111, 1'b1);
    step(6'b111111, 1'b1);
    lit("reset", 5'b0_0000);
`ifdef BIT6_POPCOUNT_EN
    lit_pc("reset_pc", 3'd0);
`endif
    rst_n  = 1'b1;
    chk_en = 1'b1;

    step(6'b000001, 1'b1);
    lit("v000001", 5'b1_0010);
    step(6'b000111, 1'b1);
    lit("v000111", 5'b1_0011);
    step(6'b101011, 1'b1);
    lit("v101011", 5'b1_0101);
    step(6'b011111, 1'b1);
    lit("v011111", 5'b1_0111);
    step(6'b111111, 1'b1);
    lit("v111111", 5'b1_1111);
`ifdef BIT6_POPCOUNT_EN
    lit_pc("pc111111", 3'd6);
`endif
    step(6'b000000, 1'b0);
    lit("hold_after_invalid", 5'b0_1111);
    step(6'b010100, 1'b0);
    lit("hold_second_cycle", 5'b0_1111);
    step(6'b100010, 1'b1);
    lit("v100010_after_gap", 5'b1_1010);

    for (int i = 0; i < 64; i++) begin
      if (i == 40) begin
        rst_n = 1'b0;
        step(6'(i), 1'b1);
        lit("midstream_reset", 5'b0_0000);
        rst_n = 1'b1;
      end else begin
        step(6'(i), 1'b1);
      end
    end
    lit("exhaustive_last_111111", 5'b1_1111);

    step(6'b110000, 1'b0);
    lit("final_hold", 5'b0_1111);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
